// File: rtl/uart_tx_framed.sv
// ----------------------------------------------------------------------------
// uart_tx_framed
//   UART transmitter fed by a small input FIFO. Each frame is one start bit,
//   DATA_W data bits (LSB first), an optional odd/even parity bit and one or
//   two stop bits. Every serial bit lasts one i_clk_en tick. Frames are sent
//   back to back with no idle tick while the FIFO holds data.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   stop bits per frame (1 or 2)
//   FIFO_DEPTH  input FIFO entries (power of two, >= 2)
//
// Ports
//   i_sys_clk     system clock
//   i_rst_n       asynchronous active-low reset
//   i_clk_en      baud tick, one i_sys_clk cycle wide
//   i_tx_en       transmitter enable; low aborts the frame in flight
//   i_tx_data     word to queue
//   i_tx_valid    producer has a word
//   o_tx_ready    FIFO can accept a word
//   o_tx          serial line, idle high, registered
//   o_busy        a frame is in progress
//   o_frame_done  one-cycle pulse when the last stop bit of a frame completes
//   o_fifo_count  words queued, excluding the frame in flight
// ----------------------------------------------------------------------------
module uart_tx_framed #(
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               i_sys_clk,
    input  logic                               i_rst_n,
    input  logic                               i_clk_en,
    input  logic                               i_tx_en,
    input  logic [DATA_W-1:0]                  i_tx_data,
    input  logic                               i_tx_valid,
    output logic                               o_tx_ready,
    output logic                               o_tx,
    output logic                               o_busy,
    output logic                               o_frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = FIFO_DEPTH[CNT_W-1:0];
    localparam logic [IDX_W-1:0] LAST_IDX  = DATA_W[IDX_W-1:0];
    localparam logic [1:0]       STOP_LAST = STOP_BITS[1:0];

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;

    logic [2:0]        state;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [IDX_W-1:0]  bit_idx;
    logic [1:0]        stop_cnt;

    logic              push;
    logic              pop;
    logic              abort;
    logic              frame_end;
    logic [DATA_W-1:0] head;
    logic              head_par;

    always_comb begin
        frame_end = (state == ST_STOP) && (stop_cnt >= STOP_LAST);
        abort     = !i_tx_en && (state != ST_IDLE);
        // A pop only happens on a tick, from IDLE or as the final stop bit
        // ends; the registered count means a word pushed on this very tick
        // is not yet visible here.
        pop       = i_tx_en && i_clk_en && (o_fifo_count != '0) &&
                    ((state == ST_IDLE) || frame_end);
        push      = i_tx_valid && o_tx_ready;
        head      = mem[rd_ptr];
        head_par  = (PARITY == 1) ? ~^head : ^head;
        count_nxt = o_fifo_count;
        if (push && !pop) begin
            count_nxt = o_fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = o_fifo_count - CNT_W'(1);
        end
    end

    // FIFO storage needs no reset; only the pointers and count do.
    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_data;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_tx_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_fifo_count <= count_nxt;
            o_tx_ready   <= (count_nxt < DEPTH_C);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            bit_idx      <= '0;
            stop_cnt     <= '0;
        end else begin
            o_frame_done <= 1'b0;
            if (abort) begin
                // Abort ignores the tick; the word in flight is dropped.
                state  <= ST_IDLE;
                o_tx   <= 1'b1;
                o_busy <= 1'b0;
            end else if (i_clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (pop) begin
                            shift_q <= head;
                            par_q   <= head_par;
                            o_tx    <= 1'b0;
                            o_busy  <= 1'b1;
                            state   <= ST_START;
                        end
                    end
                    ST_START: begin
                        o_tx    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_idx <= IDX_W'(1);
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_idx < LAST_IDX) begin
                            o_tx    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                        end else if (PARITY != 0) begin
                            o_tx  <= par_q;
                            state <= ST_PAR;
                        end else begin
                            o_tx     <= 1'b1;
                            stop_cnt <= 2'd1;
                            state    <= ST_STOP;
                        end
                    end
                    ST_PAR: begin
                        o_tx     <= 1'b1;
                        stop_cnt <= 2'd1;
                        state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (stop_cnt < STOP_LAST) begin
                            o_tx     <= 1'b1;
                            stop_cnt <= stop_cnt + 2'd1;
                        end else begin
                            o_frame_done <= 1'b1;
                            if (pop) begin
                                // Next start bit follows the last stop bit
                                // directly, with no idle tick.
                                shift_q <= head;
                                par_q   <= head_par;
                                o_tx    <= 1'b0;
                                state   <= ST_START;
                            end else begin
                                o_tx   <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        o_tx   <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_framed
//   Directed bench for uart_tx_framed. Five instances share clock, reset and
//   baud tick: 0 defaults, 1 odd parity / 2 stop, 2 even parity / 2 stop,
//   3 DATA_W=5, 4 DATA_W=9. The baud tick fires every 4 clocks.
// ----------------------------------------------------------------------------
module tb_uart_tx_framed;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clk_en = 1'b0;
    logic [1:0] div    = 2'd0;

    logic [8:0] d_data = '0;
    logic [4:0] valid  = '0;
    logic [4:0] en     = '1;

    logic [4:0]      tx, ready, busy, done;
    logic [4:0][2:0] cnt;
    int              done_cnt [5];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div    <= div + 2'd1;
        clk_en <= (div == 2'd2);
    end

    initial for (int i = 0; i < 5; i++) done_cnt[i] = 0;
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    uart_tx_framed u_def (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_tx_en(en[0]),
        .i_tx_data(d_data[7:0]), .i_tx_valid(valid[0]), .o_tx_ready(ready[0]),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_frame_done(done[0]), .o_fifo_count(cnt[0]));

    uart_tx_framed #(.PARITY(1), .STOP_BITS(2)) u_odd (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_tx_en(en[1]),
        .i_tx_data(d_data[7:0]), .i_tx_valid(valid[1]), .o_tx_ready(ready[1]),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_frame_done(done[1]), .o_fifo_count(cnt[1]));

    uart_tx_framed #(.PARITY(2), .STOP_BITS(2)) u_even (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_tx_en(en[2]),
        .i_tx_data(d_data[7:0]), .i_tx_valid(valid[2]), .o_tx_ready(ready[2]),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_frame_done(done[2]), .o_fifo_count(cnt[2]));

    uart_tx_framed #(.DATA_W(5)) u_w5 (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_tx_en(en[3]),
        .i_tx_data(d_data[4:0]), .i_tx_valid(valid[3]), .o_tx_ready(ready[3]),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_frame_done(done[3]), .o_fifo_count(cnt[3]));

    uart_tx_framed #(.DATA_W(9)) u_w9 (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_tx_en(en[4]),
        .i_tx_data(d_data[8:0]), .i_tx_valid(valid[4]), .o_tx_ready(ready[4]),
        .o_tx(tx[4]), .o_busy(busy[4]), .o_frame_done(done[4]), .o_fifo_count(cnt[4]));

    // Advance to the next clock edge that carries a baud tick, then settle.
    task automatic tick_edge;
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!clk_en && n < 16);
        if (!clk_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no baud tick within %0d clocks", n);
        end
        #1;
    endtask

    task automatic push(input int k, input logic [8:0] d, output logic acc);
        @(negedge clk);
        acc      = ready[k];
        d_data   = d;
        valid[k] = 1'b1;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
    endtask

    task automatic capture(input int k, input int nb, output logic [63:0] bits,
                           output logic busy_ok);
        bits    = '0;
        busy_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            tick_edge();
            bits[i] = tx[k];
            if (busy[k] !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic set_en(input int k, input logic v);
        @(negedge clk);
        en[k] = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (tx !== 5'b11111) begin n_fail++; $display("FAIL reset_tx: got %b want 11111", tx); end
        n_tests++; if (ready !== 5'b11111) begin n_fail++; $display("FAIL reset_ready: got %b want 11111", ready); end
        n_tests++; if (busy !== 5'b00000) begin n_fail++; $display("FAIL reset_busy: got %b want 00000", busy); end
        n_tests++; if (done !== 5'b00000) begin n_fail++; $display("FAIL reset_done: got %b want 00000", done); end
        n_tests++; if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt[0]); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        logic acc, bok;
        logic [63:0] bits;
        int d0;
        d0 = done_cnt[0];
        push(0, 9'h0A5, acc);
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b want 1", acc); end
        capture(0, 10, bits, bok);
        // start 0, A5 LSB first 1,0,1,0,0,1,0,1, stop 1
        n_tests++; if (bits[9:0] !== 10'h34A) begin n_fail++; $display("FAIL basic_bits: got %h want 34a", bits[9:0]); end
        n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", bok); end
        tick_edge();
        n_tests++; if (done[0] !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done[0]); end
        n_tests++; if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin n_fail++; $display("FAIL basic_idle: busy %b tx %b want 0 1", busy[0], tx[0]); end
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (done_cnt[0] - d0 !== 1) begin n_fail++; $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt[0] - d0); end
    endtask

    task automatic test_parity;
        logic acc, bok;
        logic [63:0] bits;
        push(1, 9'h007, acc);
        capture(1, 12, bits, bok);
        // start, 1,1,1,0,0,0,0,0, odd parity 0, stop, stop
        n_tests++; if (bits[11:0] !== 12'hC0E) begin n_fail++; $display("FAIL odd_bits: got %h want c0e", bits[11:0]); end
        tick_edge();
        n_tests++; if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL odd_end: done %b busy %b want 1 0", done[1], busy[1]); end
        push(2, 9'h007, acc);
        capture(2, 12, bits, bok);
        n_tests++; if (bits[11:0] !== 12'hE0E) begin n_fail++; $display("FAIL even_bits: got %h want e0e", bits[11:0]); end
        tick_edge();
        n_tests++; if (done[2] !== 1'b1 || busy[2] !== 1'b0) begin n_fail++; $display("FAIL even_end: done %b busy %b want 1 0", done[2], busy[2]); end
    endtask

    task automatic test_back_to_back;
        logic acc, bok;
        logic [63:0] bits, exp;
        logic [4:0] accs;
        logic [7:0] w [4];
        int d0;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'hC3; w[3] = 8'h7E;
        set_en(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push(0, {1'b0, w[i]}, acc);
            accs[i] = acc;
        end
        n_tests++; if (cnt[0] !== 3'd4) begin n_fail++; $display("FAIL b2b_count_full: got %0d want 4", cnt[0]); end
        n_tests++; if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b want 0", ready[0]); end
        push(0, 9'h055, acc);
        accs[4] = acc;
        n_tests++; if (accs !== 5'b01111) begin n_fail++; $display("FAIL b2b_accepts: got %b want 01111", accs); end
        n_tests++; if (cnt[0] !== 3'd4) begin n_fail++; $display("FAIL b2b_count_held: got %0d want 4", cnt[0]); end
        d0 = done_cnt[0];
        exp = '0;
        for (int i = 0; i < 4; i++) exp[i*10 +: 10] = {1'b1, w[i], 1'b0};
        set_en(0, 1'b1);
        capture(0, 40, bits, bok);
        n_tests++; if (bits[39:0] !== exp[39:0]) begin n_fail++; $display("FAIL b2b_bits: got %h want %h", bits[39:0], exp[39:0]); end
        n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: busy dropped between frames"); end
        tick_edge();
        n_tests++; if (busy[0] !== 1'b0 || cnt[0] !== 3'd0) begin n_fail++; $display("FAIL b2b_end: busy %b count %0d want 0 0", busy[0], cnt[0]); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (done_cnt[0] - d0 !== 4) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 4", done_cnt[0] - d0); end
    endtask

    task automatic test_abort;
        logic acc, bok;
        logic [63:0] bits;
        int d0;
        set_en(0, 1'b0);
        push(0, 9'h03C, acc);
        push(0, 9'h081, acc);
        set_en(0, 1'b1);
        capture(0, 3, bits, bok);
        n_tests++; if (bits[2:0] !== 3'b000) begin n_fail++; $display("FAIL abort_pre_bits: got %b want 000", bits[2:0]); end
        d0 = done_cnt[0];
        set_en(0, 1'b0);
        @(posedge clk);
        #1;
        n_tests++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: tx %b busy %b want 1 0", tx[0], busy[0]); end
        n_tests++; if (cnt[0] !== 3'd1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", cnt[0]); end
        repeat (3) tick_edge();
        n_tests++; if (tx[0] !== 1'b1 || done_cnt[0] !== d0) begin n_fail++; $display("FAIL abort_quiet: tx %b pulses %0d want 1 0", tx[0], done_cnt[0] - d0); end
        set_en(0, 1'b1);
        capture(0, 10, bits, bok);
        n_tests++; if (bits[9:0] !== 10'h302) begin n_fail++; $display("FAIL abort_resume_bits: got %h want 302", bits[9:0]); end
        tick_edge();
        n_tests++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_resume_end: done %b busy %b want 1 0", done[0], busy[0]); end
    endtask

    task automatic test_async_reset;
        logic acc, bok;
        logic [63:0] bits;
        set_en(0, 1'b0);
        push(0, 9'h000, acc);
        push(0, 9'h0FF, acc);
        set_en(0, 1'b1);
        capture(0, 3, bits, bok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (tx[0] !== 1'b1 || cnt[0] !== 3'd0) begin n_fail++; $display("FAIL areset_now: tx %b count %0d want 1 0", tx[0], cnt[0]); end
        n_tests++; if (busy[0] !== 1'b0 || ready[0] !== 1'b1) begin n_fail++; $display("FAIL areset_flags: busy %b ready %b want 0 1", busy[0], ready[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(0, 9'h096, acc);
        capture(0, 10, bits, bok);
        n_tests++; if (bits[9:0] !== 10'h32C) begin n_fail++; $display("FAIL areset_new_bits: got %h want 32c", bits[9:0]); end
        tick_edge();
        n_tests++; if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin n_fail++; $display("FAIL areset_fifo_cleared: busy %b tx %b want 0 1", busy[0], tx[0]); end
    endtask

    task automatic test_widths;
        logic acc, bok;
        logic [63:0] bits;
        push(3, 9'h015, acc);
        capture(3, 7, bits, bok);
        n_tests++; if (bits[6:0] !== 7'h6A) begin n_fail++; $display("FAIL w5_bits: got %h want 6a", bits[6:0]); end
        tick_edge();
        n_tests++; if (done[3] !== 1'b1 || busy[3] !== 1'b0) begin n_fail++; $display("FAIL w5_len: done %b busy %b want 1 0", done[3], busy[3]); end
        push(4, 9'h1AA, acc);
        capture(4, 11, bits, bok);
        n_tests++; if (bits[10:0] !== 11'h754) begin n_fail++; $display("FAIL w9_bits: got %h want 754", bits[10:0]); end
        tick_edge();
        n_tests++; if (done[4] !== 1'b1 || busy[4] !== 1'b0) begin n_fail++; $display("FAIL w9_len: done %b busy %b want 1 0", done[4], busy[4]); end
    endtask

    task automatic test_push_pop_same_cycle;
        logic acc;
        set_en(0, 1'b0);
        push(0, 9'h011, acc);
        push(0, 9'h022, acc);
        n_tests++; if (cnt[0] !== 3'd2) begin n_fail++; $display("FAIL pp_pre_count: got %0d want 2", cnt[0]); end
        tick_edge();
        // Fourth falling edge after a tick precedes the next tick edge.
        repeat (4) @(negedge clk);
        d_data   = 9'h033;
        valid[0] = 1'b1;
        en[0]    = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        n_tests++; if (cnt[0] !== 3'd2) begin n_fail++; $display("FAIL pp_count: got %0d want 2", cnt[0]); end
        n_tests++; if (busy[0] !== 1'b1 || tx[0] !== 1'b0) begin n_fail++; $display("FAIL pp_started: busy %b tx %b want 1 0", busy[0], tx[0]); end
        set_en(0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_widths();
        test_push_pop_same_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
